// File: rtl/crosshair_shot_ctrl.sv
// crosshair_shot_ctrl: clamps mouse position to a crosshair and turns debounced left clicks into rate-limited, ammo-limited shots
module crosshair_shot_ctrl #(
    parameter int SCREEN_W        = 640,
    parameter int SCREEN_H        = 480,
    parameter int COOLDOWN_CYCLES = 5000000,
    parameter int AMMO_MAX        = 3
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] mousex,
    input  logic [31:0] mousey,
    input  logic [7:0]  mousebutton,
    input  logic        frame_sync,
    input  logic        round_start,
    input  logic        shot_ready,
    output logic [9:0]  cross_x,
    output logic [9:0]  cross_y,
    output logic        shot_valid,
    output logic [9:0]  shot_x,
    output logic [9:0]  shot_y,
    output logic [1:0]  ammo,
    output logic        dry_fire,
    output logic [7:0]  shots_fired
);
    localparam int CW = $clog2(COOLDOWN_CYCLES + 1);
    typedef enum logic [1:0] {ARMED, FIRE, COOLDOWN} state_t;
    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            s1, s2, s3, click, dry_n;
    logic [9:0]      cx_n, cy_n, sx_n, sy_n;
    logic [1:0]      ammo_n;
    logic [7:0]      sf_n;
    logic            btn_unused;
    assign btn_unused = ^mousebutton[7:1];
    assign click      = s2 & ~s3;
    assign shot_valid = (state == FIRE);
    assign cx_n = !frame_sync ? cross_x :
                  $signed(mousex) < 0 ? 10'd0 :
                  $signed(mousex) >= SCREEN_W ? 10'(SCREEN_W - 1) : mousex[9:0];
    assign cy_n = !frame_sync ? cross_y :
                  $signed(mousey) < 0 ? 10'd0 :
                  $signed(mousey) >= SCREEN_H ? 10'(SCREEN_H - 1) : mousey[9:0];
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sx_n    = shot_x;
        sy_n    = shot_y;
        ammo_n  = round_start ? 2'(AMMO_MAX) : ammo;
        dry_n   = 1'b0;
        sf_n    = shots_fired;
        case (state)
            ARMED: begin
                if (click && ammo_n != 2'd0) begin
                    state_n = FIRE;
                    sx_n    = cross_x;
                    sy_n    = cross_y;
                    ammo_n  = ammo_n - 2'd1;
                end else if (click) begin
                    dry_n = 1'b1;
                end
            end
            FIRE: begin
                if (shot_ready) begin
                    state_n = COOLDOWN;
                    cnt_n   = CW'(COOLDOWN_CYCLES - 1);
                    sf_n    = shots_fired == 8'hff ? shots_fired : shots_fired + 8'd1;
                end
            end
            COOLDOWN: begin
                if (cnt == '0) state_n = ARMED;
                else cnt_n = cnt - CW'(1);
            end
            default: state_n = ARMED;
        endcase
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= ARMED;
            cnt         <= '0;
            cross_x     <= 10'(SCREEN_W / 2);
            cross_y     <= 10'(SCREEN_H / 2);
            shot_x      <= 10'd0;
            shot_y      <= 10'd0;
            ammo        <= 2'(AMMO_MAX);
            dry_fire    <= 1'b0;
            shots_fired <= 8'd0;
            s1          <= 1'b0;
            s2          <= 1'b0;
            s3          <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            cross_x     <= cx_n;
            cross_y     <= cy_n;
            shot_x      <= sx_n;
            shot_y      <= sy_n;
            ammo        <= ammo_n;
            dry_fire    <= dry_n;
            shots_fired <= sf_n;
            s1          <= mousebutton[0];
            s2          <= s1;
            s3          <= s2;
        end
    end
endmodule

// File: doc/crosshair_shot_ctrl.md
CROSSHAIR_SHOT_CTRL -- requirements
Module: crosshair_shot_ctrl

Parameters
REQ-001 SHALL have SCREEN_W, default 640, visible width in pixels.
REQ-002 SHALL have SCREEN_H, default 480, visible height in pixels.
REQ-003 SHALL have COOLDOWN_CYCLES, default 5000000, minimum Clk cycles between shots (100 ms at 50 MHz), legal range >= 1.
REQ-004 SHALL have AMMO_MAX, default 3, shots per round, legal range 1..3.

Interface
REQ-005 SHALL have Clk  input  1  single system clock; all logic on its rising edge.
REQ-006 SHALL have Reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have mousex  input  32  signed X from the USB mouse export (two's complement).
REQ-008 SHALL have mousey  input  32  signed Y from the USB mouse export (two's complement).
REQ-009 SHALL have mousebutton  input  8  button bits; bit0 is the left button; asynchronous to Clk.
REQ-010 SHALL have frame_sync  input  1  one-cycle pulse at the start of vertical blank.
REQ-011 SHALL have round_start  input  1  one-cycle pulse that reloads ammo.
REQ-012 SHALL have shot_ready  input  1  downstream hit-test accepts the shot.
REQ-013 SHALL have cross_x  output  10  clamped crosshair X.
REQ-014 SHALL have cross_y  output  10  clamped crosshair Y.
REQ-015 SHALL have shot_valid  output  1  shot pending.
REQ-016 SHALL have shot_x  output  10  latched shot X.
REQ-017 SHALL have shot_y  output  10  latched shot Y.
REQ-018 SHALL have ammo  output  2  rounds remaining.
REQ-019 SHALL have dry_fire  output  1  one-cycle pulse on a click with no ammo.
REQ-020 SHALL have shots_fired  output  8  count of accepted shots, saturating at 255.

Function
REQ-021 SHALL update cross_x/cross_y only on cycles where frame_sync=1; outputs hold between pulses.
REQ-022 SHALL clamp each coordinate independently: value < 0 -> 0; value >= SCREEN_W (or SCREEN_H) -> SCREEN_W-1 (or SCREEN_H-1); otherwise the low 10 bits.
REQ-023 SHALL synchronise mousebutton[0] through two flops and detect a rising edge as sync=1 and previous sync=0; a held button produces exactly one edge.
REQ-024 SHALL implement FSM states ARMED, FIRE and COOLDOWN.
REQ-025 In ARMED, on an edge with ammo>0, SHALL move to FIRE, latch shot_x/shot_y from the current cross_x/cross_y, and decrement ammo.
REQ-026 In ARMED, on an edge with ammo=0, SHALL stay in ARMED and pulse dry_fire for one cycle.
REQ-027 shot_valid SHALL equal (state==FIRE); shot_x/shot_y SHALL remain stable while shot_valid=1.
REQ-028 In FIRE with shot_ready=1, SHALL move to COOLDOWN, load the counter with COOLDOWN_CYCLES-1, and increment shots_fired (saturating).
REQ-029 In COOLDOWN, SHALL decrement the counter each cycle and move to ARMED in the cycle after the counter reads 0; COOLDOWN SHALL last exactly COOLDOWN_CYCLES cycles.
REQ-030 Edges occurring in FIRE or COOLDOWN SHALL be discarded (not queued) and SHALL NOT pulse dry_fire.
REQ-031 Latency: shot_valid SHALL rise on the 3rd rising Clk edge after mousebutton[0] rises (setup met), when ARMED with ammo>0.
REQ-032 round_start SHALL set ammo to AMMO_MAX in any state; a pending shot in FIRE SHALL be kept.
REQ-033 When round_start and a firing edge coincide in ARMED, SHALL apply the reload first, then the shot, leaving ammo=AMMO_MAX-1.
REQ-034 When frame_sync and a firing edge coincide, SHALL latch the pre-update cross_x/cross_y into shot_x/shot_y.

Reset
REQ-035 On Reset=1 at a Clk edge, SHALL set state=ARMED, cross_x=SCREEN_W/2, cross_y=SCREEN_H/2, shot_x=shot_y=0, shot_valid=0, ammo=AMMO_MAX, dry_fire=0, shots_fired=0, counter=0, and synchroniser/edge flops=0.
REQ-036 Reset SHALL override all inputs, including mid-FIRE and mid-COOLDOWN; a pending shot SHALL be dropped.

Verification
REQ-037 mousex=-5, mousey=700, frame_sync pulse -> cross_x=0, cross_y=479; without frame_sync, outputs are unchanged.
REQ-038 cross=(100,200), button rise -> shot_valid=1 at the 3rd edge with shot=(100,200) and ammo=2; hold shot_ready=0 for 10 cycles -> shot_valid stays 1 and coordinates are stable.
REQ-039 COOLDOWN_CYCLES=4, shot accepted -> exactly 4 COOLDOWN cycles, then ARMED; a click during COOLDOWN produces no shot and no dry_fire; shots_fired increments by 1.
REQ-040 Three accepted shots, then a fourth click -> one-cycle dry_fire and ammo=0; then round_start -> ammo=3.
REQ-041 round_start in the same cycle as a firing edge in ARMED with ammo=0 -> shot issued and ammo=2.
REQ-042 Reset asserted while in FIRE -> next cycle shot_valid=0, ammo=3, and cross=(320,240).
